// File: rtl/irq_controller.sv
// ----------------------------------------------------------------------------
// irq_controller
//
// Eight-source interrupt controller on the CPU IO bus. Every source goes
// through a two-flop synchronizer. It is then treated as either a
// rising-edge source, which latches into PENDING until it is cleared by a
// write-1-to-clear, or a level source, where PENDING follows the
// synchronized input. PENDING masked by ENABLE drives a registered request
// to the CPU. VECTOR reports the highest-priority active source, and bit 0
// is the highest priority.
//
// Register map (word offsets, io_addr[3:1]):
//   0 PENDING  R / W1C
//   1 ENABLE   R/W [7:0]
//   2 EDGE     R/W [7:0]   1 = rising edge, 0 = level
//   3 VECTOR   R           [15] = no source active, [2:0] = lowest active index
//   4 SWSET    W           write-1-sets-pending (edge sources only)
//   5-7        read 0, writes ignored
//
// Ports:
//   clk               system clock, rising edge
//   resetq            asynchronous active-low reset
//   io_rd             CPU IO read strobe (reads have no side effects)
//   io_wr             CPU IO write strobe
//   io_addr[15:0]     CPU IO address; block selected when [15:4] == BASE[15:4]
//   io_dout[15:0]     CPU write data
//   irq_src[7:0]      asynchronous interrupt sources
//   rd_data[15:0]     combinational read data, 0 when not selected
//   interrupt_request registered request to the CPU
// ----------------------------------------------------------------------------
module irq_controller #(
    parameter logic [15:0] BASE = 16'h0040
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    input  logic [7:0]  irq_src,
    output logic [15:0] rd_data,
    output logic        interrupt_request
);

    localparam logic [2:0] OFF_PENDING = 3'd0;
    localparam logic [2:0] OFF_ENABLE  = 3'd1;
    localparam logic [2:0] OFF_EDGE    = 3'd2;
    localparam logic [2:0] OFF_VECTOR  = 3'd3;
    localparam logic [2:0] OFF_SWSET   = 3'd4;

    logic [7:0]  s1, s2, s3;
    logic [7:0]  pending;
    logic [7:0]  enable;
    logic [7:0]  edge_mode;

    logic        sel;
    logic [2:0]  offset;
    logic        wr_hit;
    logic [7:0]  w1c_mask;
    logic [7:0]  swset_mask;
    logic [7:0]  rise;
    logic [7:0]  pending_next;
    logic [7:0]  active;
    logic [2:0]  active_idx;
    logic [15:0] vector;

    // Reads are side-effect free and the address LSB / write upper byte
    // carry no meaning here.
    logic        unused_bits;
    assign unused_bits = ^{io_rd, io_addr[0], io_dout[15:8]};

    assign sel    = (io_addr[15:4] == BASE[15:4]);
    assign offset = io_addr[3:1];
    assign wr_hit = io_wr & sel;

    assign w1c_mask   = (wr_hit && offset == OFF_PENDING) ? io_dout[7:0] : 8'h00;
    assign swset_mask = (wr_hit && offset == OFF_SWSET)   ? io_dout[7:0] : 8'h00;

    assign rise = s2 & ~s3;

    // Edge bits: a set event (hardware edge or SWSET) beats a same-cycle
    // W1C. Level bits ignore both and simply track the synchronized input.
    assign pending_next = (edge_mode & ((pending & ~w1c_mask) | rise | swset_mask))
                        | (~edge_mode & s2);

    assign active = pending & enable;

    // Scan from the top down so the lowest set index is the one that sticks.
    always_comb begin
        active_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                active_idx = 3'(i);
            end
        end
    end

    assign vector = {~|active, 12'h000, active_idx};

    always_comb begin
        rd_data = 16'h0000;
        if (sel) begin
            case (offset)
                OFF_PENDING: rd_data = {8'h00, pending};
                OFF_ENABLE:  rd_data = {8'h00, enable};
                OFF_EDGE:    rd_data = {8'h00, edge_mode};
                OFF_VECTOR:  rd_data = vector;
                default:     rd_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            s1 <= 8'h00;
            s2 <= 8'h00;
            s3 <= 8'h00;
        end else begin
            s1 <= irq_src;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            pending           <= 8'h00;
            enable            <= 8'h00;
            edge_mode         <= 8'h00;
            interrupt_request <= 1'b0;
        end else begin
            pending           <= pending_next;
            interrupt_request <= |active;
            if (wr_hit && offset == OFF_ENABLE) begin
                enable <= io_dout[7:0];
            end
            if (wr_hit && offset == OFF_EDGE) begin
                edge_mode <= io_dout[7:0];
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// ----------------------------------------------------------------------------
// tb_irq_controller
//
// Directed scenarios followed by a randomized bus/source run, each step
// compared against a behavioural model of the controller held in this file.
// ----------------------------------------------------------------------------
module tb_irq_controller;

    localparam logic [15:0] BASE = 16'h0040;

    logic        clk;
    logic        resetq;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [7:0]  irq_src;
    logic [15:0] rd_data;
    logic        interrupt_request;

    int vectors;
    int miscompares;

    // Behavioural model state
    logic [7:0] m_pend, m_en, m_edge;
    logic       m_req;
    logic [7:0] hist[$];   // irq_src sampled at past posedges, newest first

    irq_controller #(.BASE(BASE)) dut (
        .clk               (clk),
        .resetq            (resetq),
        .io_rd             (io_rd),
        .io_wr             (io_wr),
        .io_addr           (io_addr),
        .io_dout           (io_dout),
        .irq_src           (irq_src),
        .rd_data           (rd_data),
        .interrupt_request (interrupt_request)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 8'h00;
        m_en   = 8'h00;
        m_edge = 8'h00;
        m_req  = 1'b0;
        hist   = {8'h00, 8'h00, 8'h00};
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        logic [7:0]  act;
        logic [15:0] v;
        if (a[15:4] != BASE[15:4]) return 16'h0000;
        act = m_pend & m_en;
        case (a[3:1])
            3'd0: return {8'h00, m_pend};
            3'd1: return {8'h00, m_en};
            3'd2: return {8'h00, m_edge};
            3'd3: begin
                v = (act == 8'h00) ? 16'h8000 : 16'h0000;
                for (int i = 0; i < 8; i++) begin
                    if (act[i]) begin
                        v[2:0] = i[2:0];
                        break;
                    end
                end
                return v;
            end
            default: return 16'h0000;
        endcase
    endfunction

    // One clock: the model applies the rules to the inputs presented before
    // the edge, then the registered request is compared just after it.
    task automatic tick();
        logic [7:0] lvl, prv, np;
        logic       hit;
        logic [2:0] off;
        logic       nreq;
        hit  = io_wr && (io_addr[15:4] == BASE[15:4]);
        off  = io_addr[3:1];
        lvl  = hist[1];   // synchronized level seen by this edge
        prv  = hist[2];   // its value one cycle earlier
        nreq = (m_pend & m_en) != 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (m_edge[i]) begin
                if ((lvl[i] && !prv[i]) || (hit && off == 3'd4 && io_dout[i]))
                    np[i] = 1'b1;
                else if (hit && off == 3'd0 && io_dout[i])
                    np[i] = 1'b0;
                else
                    np[i] = m_pend[i];
            end else begin
                np[i] = lvl[i];
            end
        end
        @(posedge clk);
        m_pend = np;
        m_req  = nreq;
        if (hit && off == 3'd1) m_en   = io_dout[7:0];
        if (hit && off == 3'd2) m_edge = io_dout[7:0];
        hist.push_front(irq_src);
        while (hist.size() > 3) void'(hist.pop_back());
        #1;
        check("req_model", {15'h0, interrupt_request}, {15'h0, m_req});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] data);
        io_addr = BASE + {12'h0, off, 1'b0};
        io_dout = data;
        io_wr   = 1'b1;
        tick();
        io_wr   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        io_addr = addr;
        io_rd   = 1'b1;
        #1;
        check(tag, rd_data, exp);
        io_rd   = 1'b0;
    endtask

    task automatic cleanup();
        irq_src = 8'h00;
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0000);
        ticks(3);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetq  = 1'b0;
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        io_addr = 16'h0000;
        io_dout = 16'h0000;
        irq_src = 8'h00;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_req", {15'h0, interrupt_request}, 16'h0000);
        resetq = 1'b1;
        tick();
        check("req_after_release", {15'h0, interrupt_request}, 16'h0000);
        rd_chk("rst_pending", BASE + 16'd0, 16'h0000);
        rd_chk("rst_enable",  BASE + 16'd2, 16'h0000);
        rd_chk("rst_edge",    BASE + 16'd4, 16'h0000);
        tick();
        rd_chk("rst_vector",  BASE + 16'd6, 16'h8000);
        rd_chk("rst_swset",   BASE + 16'd8, 16'h0000);

        // Single-cycle pulse on an edge source: 4 posedges to request
        wr(3'd2, 16'h0004);
        wr(3'd1, 16'h0004);
        ticks(3);
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        check("edge_lat1", {15'h0, interrupt_request}, 16'h0000);
        tick();
        check("edge_lat2", {15'h0, interrupt_request}, 16'h0000);
        tick();
        check("edge_lat3", {15'h0, interrupt_request}, 16'h0000);
        tick();
        check("edge_lat4", {15'h0, interrupt_request}, 16'h0001);
        rd_chk("edge_vector", BASE + 16'd6, 16'h0002);
        wr(3'd0, 16'h0004);
        rd_chk("edge_w1c_pending", BASE + 16'd0, 16'h0000);
        tick();
        check("edge_w1c_req", {15'h0, interrupt_request}, 16'h0000);

        // Level sources: W1C ignored, vector follows the inputs
        cleanup();
        wr(3'd1, 16'h00FF);
        irq_src = 8'h22;
        ticks(3);
        rd_chk("lvl_vector1", BASE + 16'd6, 16'h0001);
        wr(3'd0, 16'h0002);
        rd_chk("lvl_w1c_ignored", BASE + 16'd0, 16'h0022);
        irq_src = 8'h20;
        ticks(2);
        rd_chk("lvl_vector_hold", BASE + 16'd6, 16'h0001);
        tick();
        rd_chk("lvl_vector5", BASE + 16'd6, 16'h0005);

        // New edge and W1C on the same cycle: set wins
        cleanup();
        wr(3'd2, 16'h0008);
        wr(3'd1, 16'h0008);
        irq_src = 8'h08;
        ticks(2);
        wr(3'd0, 16'h0008);
        rd_chk("set_beats_w1c", BASE + 16'd0, 16'h0008);
        tick();
        check("set_beats_w1c_req", {15'h0, interrupt_request}, 16'h0001);
        wr(3'd0, 16'h0008);
        rd_chk("plain_w1c", BASE + 16'd0, 16'h0000);

        // Software set on a masked edge source, then unmask
        cleanup();
        wr(3'd2, 16'h0080);
        wr(3'd4, 16'h0080);
        rd_chk("swset_pending", BASE + 16'd0, 16'h0080);
        tick();
        check("swset_masked_req", {15'h0, interrupt_request}, 16'h0000);
        wr(3'd1, 16'h0080);
        check("unmask_req0", {15'h0, interrupt_request}, 16'h0000);
        tick();
        check("unmask_req1", {15'h0, interrupt_request}, 16'h0001);

        // Randomized traffic, including simultaneous read/write and
        // accesses outside the block
        for (int c = 0; c < 600; c++) begin
            logic [15:0] a;
            if ($urandom_range(0, 9) < 8) begin
                a = {BASE[15:4], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            end else begin
                a = 16'($urandom);
                if (a[15:4] == BASE[15:4]) a[4] = ~a[4];
            end
            if ($urandom_range(0, 3) == 0) irq_src = 8'($urandom);
            io_addr = a;
            io_dout = 16'($urandom);
            io_wr   = ($urandom_range(0, 3) == 0);
            io_rd   = ($urandom_range(0, 1) == 1);
            #1;
            if (io_rd) check("rand_rd", rd_data, model_read(io_addr));
            tick();
            io_wr = 1'b0;
            io_rd = 1'b0;
        end

        // Reset while a request is up
        cleanup();
        wr(3'd1, 16'h0001);
        irq_src = 8'h01;
        ticks(4);
        check("pre_reset_req", {15'h0, interrupt_request}, 16'h0001);
        #2;
        resetq = 1'b0;
        #1;
        check("async_reset_req", {15'h0, interrupt_request}, 16'h0000);
        model_reset();
        rd_chk("reset_pending", BASE, 16'h0000);
        rd_chk("outside_block", BASE + 16'd16, 16'h0000);
        @(posedge clk);
        #1;
        check("held_reset_req", {15'h0, interrupt_request}, 16'h0000);
        resetq = 1'b1;
        tick();
        check("first_edge_req", {15'h0, interrupt_request}, 16'h0000);
        rd_chk("post_reset_vector", BASE + 16'd6, 16'h8000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter BASE, default 16'h0040: IO address of register offset 0; io_addr[15:4] must equal BASE[15:4] to select the block.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 resetq  input  1  asynchronous, active-low reset.
REQ-004 io_rd  input  1  CPU IO read strobe.
REQ-005 io_wr  input  1  CPU IO write strobe.
REQ-006 io_addr  input  16  CPU IO address.
REQ-007 io_dout  input  16  CPU write data.
REQ-008 irq_src  input  8  asynchronous interrupt sources; bit 0 has the highest priority.
REQ-009 rd_data  output  16  read data, combinational; 0 when the block is not selected, so it can be ORed onto the io_din bus.
REQ-010 interrupt_request  output  1  registered request to the CPU interrupt_request pin.

Function
REQ-011 Selection: sel = (io_addr[15:4] == BASE[15:4]); offset = io_addr[3:1]; io_addr[0] ignored.
REQ-012 Register map:
- offset 0 PENDING: R, W1C.
- offset 1 ENABLE: R/W, bits [7:0].
- offset 2 EDGE: R/W, 1 = rising-edge source, 0 = level source.
- offset 3 VECTOR: R only.
- offset 4 SWSET: W, write-1-sets-pending.
- Offsets 5-7 read 0 and ignore writes.
- Upper byte [15:8] reads 0 except in VECTOR.
REQ-013 rd_data is valid in the same cycle as io_rd, combinationally from io_addr and register state; io_rd itself causes no side effects.
REQ-014 Writes take effect at the posedge where io_wr=1 and sel=1.
REQ-015 Synchronizer: each irq_src bit passes through two flops (s1, s2); a third flop s3 holds the previous s2 value for edge detection.
REQ-016 Edge source i: pending[i] sets on cycles where s2[i]=1 and s3[i]=0; it clears only by a W1C write.
REQ-017 Level source i: pending[i] is loaded each cycle with s2[i]; W1C and SWSET writes to that bit have no effect.
REQ-018 Simultaneous events on an edge bit: set (hardware edge or SWSET) wins over W1C in the same cycle.
REQ-019 SWSET applies to edge sources only, with the same timing as a W1C write.
REQ-020 active = pending & ENABLE; interrupt_request <= |active on each posedge, giving 1 cycle latency from a pending/enable change.
REQ-021 VECTOR read value:
- bit 15 = ~|active.
- bits [2:0] = index of the lowest set bit of active, or 0 when none is set.
- bits [14:3] = 0.
REQ-022 Source-to-request latency: an edge on irq_src reaches interrupt_request after 4 posedges (s1, s2, pending, request).
REQ-023 Clearing: interrupt_request deasserts on the posedge after the W1C write that clears the last active bit, or after an ENABLE write that masks it.
REQ-024 Writing EDGE from 1 to 0 makes that pending bit follow the level on the next cycle.
- Writing EDGE from 0 to 1 leaves pending as-is until it is cleared by W1C.
REQ-025 io_rd and io_wr asserted together: the write proceeds and rd_data reflects pre-write state.
REQ-026 Accesses with sel=0 change no state and leave rd_data=0.

Reset
REQ-027 resetq low asynchronously clears s1, s2, s3, PENDING, ENABLE, EDGE and interrupt_request to 0.
REQ-028 Reset asserted mid-operation discards all pending state; interrupt_request is 0 while reset is held and on the first posedge after release.
REQ-029 After reset, all sources are level type and masked; VECTOR reads 16'h8000.

Verification
REQ-030 Reset, then read offsets 0-4 at BASE -> reads 0, 0, 0, 16'h8000, 0.
REQ-031 EDGE=8'h04, ENABLE=8'h04, pulse irq_src[2] for 1 cycle -> interrupt_request=1 exactly 4 posedges after the pulse, VECTOR=16'h0002; W1C 16'h0004 -> request 0 the next cycle.
REQ-032 Level sources 1 and 5 both high, ENABLE=8'hFF -> VECTOR=16'h0001; W1C 16'h0002 -> pending bit 1 stays 1; drop irq_src[1] -> VECTOR=16'h0005 three cycles later.
REQ-033 Edge source 3 enabled, W1C 16'h0008 issued in the same cycle a new synchronized edge arrives -> pending[3] remains 1.
REQ-034 SWSET 16'h0080 with EDGE=8'h80 and ENABLE=0 -> PENDING=8'h80, interrupt_request=0; ENABLE=8'h80 -> request 1 one cycle later.
REQ-035 Assert resetq low while interrupt_request=1 -> output 0 immediately (asynchronous); io_rd at address BASE+16 -> rd_data=0.
